// File: rtl/rs_ff_driver.sv
// -----------------------------------------------------------------------------
// rs_ff_driver
//   Command-side driver for an rs_ff. A one-bit "make Q equal X" request is
//   turned into a single S or R pulse of PULSE_W cycles. The driver then
//   watches q/qbar until the flop reports the target value. Every accepted
//   request ends in exactly one completion pulse:
//     done : q_fb matched the target
//     err  : no match within TIMEOUT samples, or q_fb == qbar_fb was seen
//   S and R are never driven high together. All outputs come straight from
//   flops.
//
// Ports
//   clk, rst_n          clock (posedge), asynchronous active-low reset
//   req_valid, req_val  request handshake and target Q value
//   req_ready           high in IDLE; request accepted on valid && ready
//   q_fb, qbar_fb       feedback from the rs_ff
//   s, r                set / reset drive to the rs_ff
//   busy                command in progress (DRIVE or WAIT)
//   done, err           one-cycle completion pulses (mutually exclusive)
//
// Parameters
//   PULSE_W  cycles s or r is held per command   (1 .. 2**CNT_W-1)
//   TIMEOUT  WAIT samples before giving up        (1 .. 2**CNT_W-1)
//   CNT_W    width of the shared pulse/timeout counter
// -----------------------------------------------------------------------------
module rs_ff_driver #(
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_val,
  output logic req_ready,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Terminal counter values. The counter counts 0..N-1 so it never needs to
  // hold N itself and cannot wrap for N <= 2**CNT_W-1.
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             target_q, target_d;
  logic             s_q,     s_d;
  logic             r_q,     r_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;
  logic             ready_q, ready_d;

  logic accept;
  assign accept = req_valid && ready_q;

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Hold everything by default; completion flags are pulses so they
    // fall back to zero unless explicitly raised this cycle.
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    s_d      = s_q;
    r_d      = r_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (accept) begin
          target_d = req_val;
          cnt_d    = '0;
          state_d  = DRIVE;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          // Exactly one of s/r is raised, so S=R=1 cannot occur.
          s_d      = req_val;
          r_d      = ~req_val;
        end
      end

      DRIVE: begin
        if (cnt_q == PULSE_LAST) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT: begin
        s_d = 1'b0;
        r_d = 1'b0;
        // An illegal q/qbar pair is reported even if q happens to match.
        if (q_fb == qbar_fb) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (q_fb == target_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // Leaving WAIT: handshake reopens on the same edge as the pulse, so
        // a new request can be taken during the done/err cycle.
        if (state_d == IDLE) begin
          busy_d  = 1'b0;
          ready_d = 1'b1;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        s_d     = 1'b0;
        r_d     = 1'b0;
        busy_d  = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      s_q      <= s_d;
      r_q      <= r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign s         = s_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign req_ready = ready_q;

endmodule

// File: tb/tb_rs_ff_driver.sv
// -----------------------------------------------------------------------------
// tb_rs_ff_driver
//   Directed bench for rs_ff_driver (PULSE_W=2, TIMEOUT=8). A behavioural
//   rs_ff is driven from s/r; its feedback can be overridden to model a stuck
//   or illegal flop. Inputs change and outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_rs_ff_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic req_valid, req_val, req_ready;
  logic q_fb, qbar_fb;
  logic s, r, busy, done, err;

  // Behavioural rs_ff plus feedback override.
  logic q_m = 1'b0;
  logic frc, fq, fqb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s)      q_m <= 1'b1;
    else if (r) q_m <= 1'b0;
  end

  assign q_fb    = frc ? fq  : q_m;
  assign qbar_fb = frc ? fqb : ~q_m;

  rs_ff_driver #(.PULSE_W(2), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_val   (req_val),
    .req_ready (req_ready),
    .q_fb      (q_fb),
    .qbar_fb   (qbar_fb),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and profile it until the completion pulse
  // plus one extra cycle (to catch a stretched pulse).
  task automatic go(input logic v, input string tag, input int es, input int er,
                    input int elat, input int ed, input int ee);
    int sc = 0, rc = 0, dc = 0, ec = 0, lat = 0;
    logic busy_at = 1'b1, rdy_at = 1'b0;
    req_valid = 1'b1;
    req_val   = v;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      if (s)    sc++;
      if (r)    rc++;
      if (done) dc++;
      if (err)  ec++;
      if ((done || err) && lat == 0) begin
        lat     = i;
        busy_at = busy;
        rdy_at  = req_ready;
      end
      if (lat != 0 && i >= lat + 1) break;
      @(negedge clk);
    end
    chk({tag, "_s_cycles"}, sc, es);
    chk({tag, "_r_cycles"}, rc, er);
    chk({tag, "_latency"},  lat, elat);
    chk({tag, "_done_cnt"}, dc, ed);
    chk({tag, "_err_cnt"},  ec, ee);
    chk({tag, "_busy_at_end"}, busy_at, 0);
    chk({tag, "_ready_at_end"}, rdy_at, 1);
  endtask

  initial begin
    int len;
    int waited;
    int seen;
    rst_n = 1'b0; req_valid = 1'b0; req_val = 1'b0;
    frc = 1'b0; fq = 1'b0; fqb = 1'b1;

    // ---- reset state ----
    @(negedge clk);
    chk("rst_s", s, 0);
    chk("rst_r", r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    #1 chk("ready_before_edge", req_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", req_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_s", s, 0);
    chk("idle_r", r, 0);

    // ---- set then reset the flop ----
    go(1'b1, "set", 2, 0, 4, 1, 0);
    chk("set_q", q_fb, 1);
    go(1'b0, "clr", 0, 2, 4, 1, 0);
    chk("clr_q", q_fb, 0);
    // Already at target: still driven, done on first WAIT sample.
    go(1'b0, "same", 0, 2, 4, 1, 0);
    chk("same_q", q_fb, 0);

    // ---- stuck flop: 8 WAIT samples then err ----
    frc = 1'b1; fq = 1'b0; fqb = 1'b1;
    go(1'b1, "stuck", 2, 0, 11, 0, 1);
    frc = 1'b0;

    // ---- illegal pair during WAIT ----
    frc = 1'b1; fq = 1'b0; fqb = 1'b1;
    req_valid = 1'b1; req_val = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("ill_s1", s, 1);
    @(negedge clk);
    chk("ill_s2", s, 1);
    @(negedge clk);
    chk("ill_s3", s, 0);
    chk("ill_busy3", busy, 1);
    chk("ill_err3", err, 0);
    fq = 1'b1;
    @(negedge clk);
    chk("ill_err", err, 1);
    chk("ill_done", done, 0);
    chk("ill_busy", busy, 0);
    frc = 1'b0;
    @(negedge clk);
    chk("ill_err_pulse", err, 0);

    // ---- valid held through a command; retaken in the pulse cycle ----
    // q_m is 1 here (stuck/illegal runs still pulsed s into the model).
    req_valid = 1'b1; req_val = 1'b0;
    @(negedge clk);
    chk("hold_r1", r, 1);
    chk("hold_rdy1", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    chk("hold_r3", r, 0);
    chk("hold_rdy3", req_ready, 0);
    chk("hold_busy3", busy, 1);
    @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_rdy4", req_ready, 1);
    @(negedge clk);
    chk("hold_reacc_busy", busy, 1);
    chk("hold_reacc_r", r, 1);
    req_valid = 1'b0;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("hold_back_idle", req_ready, 1);
    @(negedge clk);

    // ---- reset in the middle of DRIVE ----
    req_valid = 1'b1; req_val = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_s", s, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s", s, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || err) seen++;
    end
    chk("mid_no_pulse", seen, 0);
    chk("mid_q_unset", q_fb, 0);
    go(1'b1, "post_rst", 2, 0, 4, 1, 0);

    // ---- random requests/resets with invariant checks ----
    for (int n = 0; n < 1000; n++) begin
      frc       = ($urandom_range(0, 3) == 0);
      fq        = 1'($urandom_range(0, 1));
      fqb       = 1'($urandom_range(0, 1));
      req_valid = 1'b1;
      req_val   = 1'($urandom_range(0, 1));
      len       = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        chk("inv_s_and_r", s & r, 0);
        chk("inv_done_and_err", done & err, 0);
        chk("inv_sr_only_busy", (s | r) & ~busy, 0);
      end
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        #1 chk("rnd_rst_sr", s | r, 0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    req_valid = 1'b0;
    frc = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
